alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_pkg.sv | 24 ++
 rtl/muldiv_sign_fix.sv | 39 +++
 rtl/alu_muldiv.sv | 209 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared constants for the M-extension multiply/divide unit: funct3 encodings
// and operand signedness helpers.
package alu_muldiv_pkg;

    localparam logic [2:0] FUNCT3_ALU_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_ALU_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_ALU_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_ALU_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_ALU_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_ALU_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_ALU_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_ALU_REMU   = 3'b111;

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == FUNCT3_ALU_MULH) || (f == FUNCT3_ALU_MULHSU) ||
               (f == FUNCT3_ALU_DIV)  || (f == FUNCT3_ALU_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == FUNCT3_ALU_MULH) || (f == FUNCT3_ALU_DIV) ||
               (f == FUNCT3_ALU_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and final sign correction for the iterative
// multiply/divide datapath; purely combinational.
module muldiv_sign_fix
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    input  logic [2*XLEN-1:0] product,
    input  logic [XLEN-1:0]   quotient,
    input  logic [XLEN-1:0]   remainder,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic [2*XLEN-1:0] product_fix,
    output logic [XLEN-1:0]   quotient_fix,
    output logic [XLEN-1:0]   remainder_fix
);

    logic neg_a;
    logic neg_b;
    logic neg_result;

    assign neg_a      = a_is_signed(funct3) & operand_a[XLEN-1];
    assign neg_b      = b_is_signed(funct3) & operand_b[XLEN-1];
    assign neg_result = neg_a ^ neg_b;

    // The most-negative value maps onto itself, which reads correctly as an
    // unsigned magnitude.
    assign mag_a = neg_a ? -operand_a : operand_a;
    assign mag_b = neg_b ? -operand_b : operand_b;

    assign product_fix   = neg_result ? -product  : product;
    assign quotient_fix  = neg_result ? -quotient : quotient;
    // Remainder follows the dividend's sign so the quotient truncates to zero.
    assign remainder_fix = neg_a ? -remainder : remainder;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M extension:
// one shift-add or restoring shift-subtract step per cycle.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t              state_reg, state_next;
    logic [2:0]          funct3_reg, funct3_next;
    logic [XLEN-1:0]     a_reg, a_next;
    logic [XLEN-1:0]     b_reg, b_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [2*XLEN-1:0]   acc_reg, acc_next;
    logic [XLEN-1:0]     result_reg, result_next;

    logic [XLEN-1:0]     mag_a, mag_b;
    logic [2*XLEN-1:0]   product_fix;
    logic [XLEN-1:0]     quotient_fix, remainder_fix;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .funct3        (funct3_reg),
        .operand_a     (a_reg),
        .operand_b     (b_reg),
        .product       (acc_reg),
        .quotient      (acc_reg[XLEN-1:0]),
        .remainder     (acc_reg[2*XLEN-1:XLEN]),
        .mag_a         (mag_a),
        .mag_b         (mag_b),
        .product_fix   (product_fix),
        .quotient_fix  (quotient_fix),
        .remainder_fix (remainder_fix)
    );

    function automatic logic div_by_zero(input logic [2:0] f, input logic [XLEN-1:0] b);
        return f[2] && (b == '0);
    endfunction

    function automatic logic div_overflow(input logic [2:0] f, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        return ((f == FUNCT3_ALU_DIV) || (f == FUNCT3_ALU_REM)) &&
               (a == MOST_NEG) && (b == '1);
    endfunction

    // Multiply consumes dividend bits LSB first, divide MSB first.
    logic [CW-1:0]   bit_idx;
    logic [XLEN-1:0] bit_hit;
    logic            a_bit;

    assign bit_idx = (state_reg == MUL) ? (CNT_LOAD - cnt_reg) : (cnt_reg - CNT_ONE);

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit_sel
            assign bit_hit[gi] = (bit_idx == CW'(gi)) & mag_a[gi];
        end
    endgenerate

    assign a_bit = |bit_hit;

    // Shift-add: upper half accumulates, the pair shifts right each step.
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;

    assign mul_addend = a_bit ? mag_b : '0;
    assign mul_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    assign mul_step   = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring divide: upper half is the partial remainder, lower the quotient.
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] div_step;

    assign rem_shift = {acc_reg[2*XLEN-1:XLEN], a_bit};
    assign div_diff  = rem_shift - {1'b0, mag_b};
    assign div_ge    = ~div_diff[XLEN];
    assign rem_new   = div_ge ? div_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign div_step  = {rem_new, acc_reg[XLEN-2:0], div_ge};

    logic            fix_zero, fix_ovf;
    logic [XLEN-1:0] fix_result;

    assign fix_zero = div_by_zero(funct3_reg, b_reg);
    assign fix_ovf  = div_overflow(funct3_reg, a_reg, b_reg);

    always_comb begin
        fix_result = product_fix[XLEN-1:0];
        case (funct3_reg)
            FUNCT3_ALU_MULH, FUNCT3_ALU_MULHSU, FUNCT3_ALU_MULHU:
                fix_result = product_fix[2*XLEN-1:XLEN];
            FUNCT3_ALU_DIV, FUNCT3_ALU_DIVU:
                fix_result = fix_zero ? '1 : (fix_ovf ? MOST_NEG : quotient_fix);
            FUNCT3_ALU_REM, FUNCT3_ALU_REMU:
                fix_result = fix_zero ? a_reg : (fix_ovf ? '0 : remainder_fix);
            default:
                fix_result = product_fix[XLEN-1:0];
        endcase
    end

    logic accept;
    logic special_in;

    assign accept     = start && !kill && ((state_reg == IDLE) || (state_reg == DONE));
    assign special_in = div_by_zero(funct3, operand_b) ||
                        div_overflow(funct3, operand_a, operand_b);

    always_comb begin
        state_next  = state_reg;
        funct3_next = funct3_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            MUL: begin
                busy     = 1'b1;
                acc_next = mul_step;
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) state_next = FIX;
            end
            DIV: begin
                busy     = 1'b1;
                acc_next = div_step;
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) state_next = FIX;
            end
            FIX: begin
                busy        = 1'b1;
                result_next = fix_result;
                state_next  = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            funct3_next = funct3;
            a_next      = operand_a;
            b_next      = operand_b;
            cnt_next    = CNT_LOAD;
            acc_next    = '0;
            if (FAST_ZERO && special_in) state_next = FIX;
            else if (funct3[2])          state_next = DIV;
            else                         state_next = MUL;
        end

        // A flush discards the operation in flight, including a pending FIX.
        if (kill) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            funct3_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            funct3_reg <= funct3_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: issued operations push expected results,
// a negedge monitor pops and compares whenever done pulses.
module tb_alu_muldiv;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    alu_muldiv #(.XLEN(XLEN), .FAST_ZERO(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clock = ~clock;

    int ec = 0;
    always @(posedge clock) ec <= ec + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_exp = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: M-extension semantics via 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa = longint'(signed'(a));
        longint      sbv = longint'(signed'(b));
        longint      ua = longint'({32'h0, a});
        logic [63:0] p;
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = sa * sbv;                return p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return MIN_VAL;
                p = sa / sbv; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / longint'({32'h0, b}); return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sbv; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % longint'({32'h0, b}); return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == MIN_VAL && b == 32'hFFFF_FFFF)))
            return 2;
        return XLEN + 2;
    endfunction

    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 exp=0 result=%h", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", ec, e.due);
                last_exp = e.res;
                $display("txn f=%0d a=%h b=%h result=%h exp=%h", e.f, e.a, e.b, result, e.res);
            end
        end
    end

    // Called at a negedge; acceptance happens on the following posedge.
    task automatic drive_now(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input bit track);
        exp_t e;
        start     = 1'b1;
        funct3    = f;
        operand_a = a;
        operand_b = b;
        if (track) begin
            e.res = ref_model(f, a, b);
            e.due = ec + ref_lat(f, a, b);
            e.f = f; e.a = a; e.b = b;
            sb.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL ready_timeout got=busy exp=idle");
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        drive_now(f, a, b, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_VAL;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = 3'd0; operand_a = 32'h0; operand_b = 32'h0;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd4, MIN_VAL, 32'hFFFF_FFFF);
        issue(3'd6, MIN_VAL, 32'hFFFF_FFFF);

        // Back-to-back: new start presented during the DONE cycle.
        issue(3'd0, 32'd1234, 32'd5678);
        begin
            int n = 0;
            while (done !== 1'b1 && n < 100) begin
                @(negedge clock);
                n++;
            end
            check("b2b_done_seen", {31'h0, done}, 32'h1);
            drive_now(3'd6, 32'hFFFF_FF00, 32'd7, 1'b1);
        end

        // Kill on cycle 10 of a divide, with a competing start.
        wait_ready();
        drain();
        drive_now(3'd5, 32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (9) @(negedge clock);
        kill = 1'b1;
        start = 1'b1; funct3 = 3'd0; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clock);
        kill = 1'b0; start = 1'b0;
        check("kill_busy", {31'h0, busy}, 32'h0);
        check("kill_result_held", result, last_exp);
        repeat (2) @(negedge clock);
        check("kill_start_ignored", {31'h0, busy}, 32'h0);
        repeat (40) @(negedge clock);
        check("kill_result_later", result, last_exp);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                funct3 = 3'($urandom_range(0, 7));
                operand_a = $urandom; operand_b = $urandom;
                @(negedge clock);
                start = 1'b0;
            end
        end

        // Reset in the middle of a multiply.
        issue(3'd0, 32'd3, 32'd5);
        wait_ready();
        drain();
        drive_now(3'd0, 32'd77, 32'd11, 1'b0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_result", result, 32'h0);
        check("midreset_done", {31'h0, done}, 32'h0);
        reset = 1'b0;
        last_exp = 32'h0;
        repeat (40) @(negedge clock);
        check("postreset_result", result, 32'h0);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
